// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: per-register enable/bubble generation for the
// in-order core, covering memory wait stalls, load-use interlock, branch
// redirect squash, stale-fetch discard, valid tracking and perf counters.
module pipe_hazard_ctrl #(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned EX_IDX     = 2,
  parameter int unsigned MEM_IDX    = 3,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned CNT_W      = 32,
  localparam int unsigned NR        = NUM_STAGES - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              imem_read,
  input  logic              imem_resp,
  input  logic              dmem_req,
  input  logic              dmem_resp,
  input  logic              branch_miss,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  output logic              load_pc,
  output logic [NR-1:0]     reg_en,
  output logic [NR-1:0]     reg_bubble,
  output logic [NR-1:0]     stage_valid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [NR-1:0]    stage_valid_q, stage_valid_d;
  logic             discard_q, discard_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic             i_wait, d_wait, lu, br;
  logic             load_pc_c;
  logic [NR-1:0]    reg_en_c, reg_bubble_c;
  logic [NR-1:0]    src_valid;

  // Hazard detection terms
  always_comb begin
    i_wait = imem_read & ~imem_resp;
    d_wait = stage_valid_q[EX_IDX] & dmem_req & ~dmem_resp;
    br     = branch_miss & stage_valid_q[EX_IDX-1];
    lu     = stage_valid_q[1] & ex_is_load & (ex_rd != '0) & stage_valid_q[0] &
             ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  end

  // Prioritised enable/bubble selection: d_wait > branch > load-use > i_wait > run
  always_comb begin
    load_pc_c    = 1'b1;
    reg_en_c     = '1;
    reg_bubble_c = '0;
    discard_d    = discard_q;
    if (d_wait) begin
      load_pc_c = 1'b0;
      for (int unsigned i = 0; i < NR; i++) begin
        if (i < MEM_IDX) reg_en_c[i] = 1'b0;
      end
      reg_bubble_c[MEM_IDX] = 1'b1;
    end else if (br) begin
      for (int unsigned i = 0; i < NR; i++) begin
        if (i < EX_IDX) reg_bubble_c[i] = 1'b1;
      end
      if (i_wait) discard_d = 1'b1;
    end else if (lu) begin
      load_pc_c       = 1'b0;
      reg_en_c[0]     = 1'b0;
      reg_bubble_c[1] = 1'b1;
    end else if (i_wait) begin
      load_pc_c       = 1'b0;
      reg_bubble_c[0] = 1'b1;
    end else if (discard_q && imem_resp) begin
      // Stale fetch from before the redirect: drop it into IF/ID as a NOP
      reg_bubble_c[0] = 1'b1;
      discard_d       = 1'b0;
    end
  end

  // Valid propagation and saturating perf counters
  always_comb begin
    src_valid = {stage_valid_q[NR-2:0], 1'b1};
    for (int unsigned i = 0; i < NR; i++) begin
      stage_valid_d[i] = reg_en_c[i] ? (~reg_bubble_c[i] & src_valid[i]) : stage_valid_q[i];
    end
    stall_cnt_d = stall_cnt_q;
    if ((d_wait | lu | i_wait) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (!d_wait && br && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid_q <= '0;
      discard_q     <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      discard_q     <= discard_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  // Control outputs are held inactive while reset is asserted
  always_comb begin
    load_pc    = rst_n & load_pc_c;
    reg_en     = rst_n ? reg_en_c : '0;
    reg_bubble = rst_n ? reg_bubble_c : '0;
  end

  assign stage_valid = stage_valid_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a narrow-counter instance for saturation.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_read, imem_resp, dmem_req, dmem_resp, branch_miss;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_is_load;
  logic        load_pc;
  logic [3:0]  reg_en, reg_bubble, stage_valid;
  logic [31:0] stall_cnt, flush_cnt;
  logic        s_load_pc;
  logic [3:0]  s_reg_en, s_reg_bubble, s_stage_valid;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int passed = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp), .branch_miss(branch_miss),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .load_pc(load_pc), .reg_en(reg_en),
    .reg_bubble(reg_bubble), .stage_valid(stage_valid), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp), .branch_miss(branch_miss),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .load_pc(s_load_pc), .reg_en(s_reg_en),
    .reg_bubble(s_reg_bubble), .stage_valid(s_stage_valid), .stall_cnt(s_stall_cnt),
    .flush_cnt(s_flush_cnt)
  );

  // Advance one clock; return 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    imem_read = 1'b1; imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0;
    branch_miss = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_is_load = 1'b0;
  endtask

  // Four free-running cycles leave every register holding a valid instruction
  task automatic refill();
    set_defaults();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    logic [3:0] exp_v [0:5];
    exp_v[0] = 4'b0001; exp_v[1] = 4'b0011; exp_v[2] = 4'b0111;
    exp_v[3] = 4'b1111; exp_v[4] = 4'b1111; exp_v[5] = 4'b1111;
    set_defaults();
    rst_n = 1'b0;
    #1;
    checks++;
    if (load_pc !== 1'b0 || reg_en !== 4'b0000 || reg_bubble !== 4'b0000) begin
      $display("FAIL reset_ctrl: load_pc=%b reg_en=%b bubble=%b, required 0/0000/0000",
               load_pc, reg_en, reg_bubble);
    end else passed++;
    checks++;
    if (stage_valid !== 4'b0000 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      $display("FAIL reset_state: valid=%b stall=%0d flush=%0d, required 0000/0/0",
               stage_valid, stall_cnt, flush_cnt);
    end else passed++;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (load_pc !== 1'b1 || reg_en !== 4'b1111 || reg_bubble !== 4'b0000) begin
      $display("FAIL release_ctrl: load_pc=%b reg_en=%b bubble=%b, required 1/1111/0000",
               load_pc, reg_en, reg_bubble);
    end else passed++;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (stage_valid !== exp_v[c] || load_pc !== 1'b1) begin
        $display("FAIL fill_cycle%0d: valid=%b load_pc=%b, required %b/1",
                 c, stage_valid, load_pc, exp_v[c]);
      end else passed++;
    end
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      $display("FAIL fill_counters: stall=%0d flush=%0d, required 0/0", stall_cnt, flush_cnt);
    end else passed++;
  endtask

  task automatic test_load_use();
    ex_is_load = 1'b1; ex_rd = 5'd5; id_use_rs1 = 1'b1; id_rs1 = 5'd5;
    #1;
    checks++;
    if (load_pc !== 1'b0 || reg_en !== 4'b1110 || reg_bubble !== 4'b0010) begin
      $display("FAIL lu_rs1_ctrl: load_pc=%b reg_en=%b bubble=%b, required 0/1110/0010",
               load_pc, reg_en, reg_bubble);
    end else passed++;
    tick();
    exp_stall++;
    checks++;
    if (stage_valid !== 4'b1101 || stall_cnt !== 32'(exp_stall)) begin
      $display("FAIL lu_rs1_state: valid=%b stall=%0d, required 1101/%0d",
               stage_valid, stall_cnt, exp_stall);
    end else passed++;
    // Load has moved on; the bubble in ID/EX must release the interlock
    checks++;
    if (load_pc !== 1'b1 || reg_en !== 4'b1111 || reg_bubble !== 4'b0000) begin
      $display("FAIL lu_one_cycle: load_pc=%b reg_en=%b bubble=%b, required 1/1111/0000",
               load_pc, reg_en, reg_bubble);
    end else passed++;
    tick();
    checks++;
    if (stall_cnt !== 32'(exp_stall)) begin
      $display("FAIL lu_stall_cnt: stall=%0d, required %0d", stall_cnt, exp_stall);
    end else passed++;
    refill();
    ex_is_load = 1'b1; ex_rd = 5'd0; id_use_rs1 = 1'b1; id_rs1 = 5'd0;
    #1;
    checks++;
    if (load_pc !== 1'b1 || reg_en !== 4'b1111 || reg_bubble !== 4'b0000) begin
      $display("FAIL lu_x0: load_pc=%b reg_en=%b bubble=%b, required 1/1111/0000",
               load_pc, reg_en, reg_bubble);
    end else passed++;
    tick();
    id_use_rs1 = 1'b0; id_rs1 = 5'd7; ex_rd = 5'd7; id_use_rs2 = 1'b1; id_rs2 = 5'd7;
    #1;
    checks++;
    if (load_pc !== 1'b0 || reg_en !== 4'b1110 || reg_bubble !== 4'b0010) begin
      $display("FAIL lu_rs2_ctrl: load_pc=%b reg_en=%b bubble=%b, required 0/1110/0010",
               load_pc, reg_en, reg_bubble);
    end else passed++;
    tick();
    exp_stall++;
    checks++;
    if (stall_cnt !== 32'(exp_stall)) begin
      $display("FAIL lu_rs2_cnt: stall=%0d, required %0d", stall_cnt, exp_stall);
    end else passed++;
    refill();
  endtask

  task automatic test_dmem_wait();
    dmem_req = 1'b1; dmem_resp = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (load_pc !== 1'b0 || reg_en !== 4'b1000 || reg_bubble !== 4'b1000) begin
        $display("FAIL dwait_cycle%0d: load_pc=%b reg_en=%b bubble=%b, required 0/1000/1000",
                 c, load_pc, reg_en, reg_bubble);
      end else passed++;
      tick();
      exp_stall++;
      checks++;
      if (stage_valid !== 4'b0111) begin
        $display("FAIL dwait_valid%0d: valid=%b, required 0111", c, stage_valid);
      end else passed++;
    end
    dmem_resp = 1'b1;
    #1;
    checks++;
    if (load_pc !== 1'b1 || reg_en !== 4'b1111 || reg_bubble !== 4'b0000) begin
      $display("FAIL dwait_release: load_pc=%b reg_en=%b bubble=%b, required 1/1111/0000",
               load_pc, reg_en, reg_bubble);
    end else passed++;
    tick();
    checks++;
    if (stall_cnt !== 32'(exp_stall) || stage_valid !== 4'b1111) begin
      $display("FAIL dwait_after: stall=%0d valid=%b, required %0d/1111",
               stall_cnt, stage_valid, exp_stall);
    end else passed++;
    refill();
  endtask

  task automatic test_branch();
    branch_miss = 1'b1; imem_read = 1'b1; imem_resp = 1'b0;
    #1;
    checks++;
    if (load_pc !== 1'b1 || reg_en !== 4'b1111 || reg_bubble !== 4'b0011) begin
      $display("FAIL br_squash: load_pc=%b reg_en=%b bubble=%b, required 1/1111/0011",
               load_pc, reg_en, reg_bubble);
    end else passed++;
    tick();
    exp_stall++;
    exp_flush++;
    checks++;
    if (flush_cnt !== 32'(exp_flush) || stage_valid !== 4'b1100) begin
      $display("FAIL br_state: flush=%0d valid=%b, required %0d/1100",
               flush_cnt, stage_valid, exp_flush);
    end else passed++;
    branch_miss = 1'b0;
    #1;
    checks++;
    if (load_pc !== 1'b0 || reg_bubble !== 4'b0001) begin
      $display("FAIL br_iwait: load_pc=%b bubble=%b, required 0/0001", load_pc, reg_bubble);
    end else passed++;
    tick();
    exp_stall++;
    imem_resp = 1'b1;
    #1;
    checks++;
    if (load_pc !== 1'b1 || reg_en !== 4'b1111 || reg_bubble !== 4'b0001) begin
      $display("FAIL br_discard: load_pc=%b reg_en=%b bubble=%b, required 1/1111/0001",
               load_pc, reg_en, reg_bubble);
    end else passed++;
    tick();
    checks++;
    if (reg_bubble !== 4'b0000 || load_pc !== 1'b1) begin
      $display("FAIL br_next_resp: load_pc=%b bubble=%b, required 1/0000", load_pc, reg_bubble);
    end else passed++;
    tick();
    checks++;
    if (stage_valid !== 4'b0001 || stall_cnt !== 32'(exp_stall)) begin
      $display("FAIL br_after: valid=%b stall=%0d, required 0001/%0d",
               stage_valid, stall_cnt, exp_stall);
    end else passed++;
    refill();
  endtask

  task automatic test_branch_dwait();
    branch_miss = 1'b1; dmem_req = 1'b1; dmem_resp = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (load_pc !== 1'b0 || reg_en !== 4'b1000 || reg_bubble !== 4'b1000) begin
        $display("FAIL brdw_hold%0d: load_pc=%b reg_en=%b bubble=%b, required 0/1000/1000",
                 c, load_pc, reg_en, reg_bubble);
      end else passed++;
      tick();
      exp_stall++;
      checks++;
      if (flush_cnt !== 32'(exp_flush)) begin
        $display("FAIL brdw_noflush%0d: flush=%0d, required %0d", c, flush_cnt, exp_flush);
      end else passed++;
    end
    dmem_resp = 1'b1;
    #1;
    checks++;
    if (load_pc !== 1'b1 || reg_en !== 4'b1111 || reg_bubble !== 4'b0011) begin
      $display("FAIL brdw_release: load_pc=%b reg_en=%b bubble=%b, required 1/1111/0011",
               load_pc, reg_en, reg_bubble);
    end else passed++;
    tick();
    exp_flush++;
    checks++;
    if (flush_cnt !== 32'(exp_flush) || stall_cnt !== 32'(exp_stall)) begin
      $display("FAIL brdw_flush: flush=%0d stall=%0d, required %0d/%0d",
               flush_cnt, stall_cnt, exp_flush, exp_stall);
    end else passed++;
    refill();
  endtask

  task automatic test_saturation();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    imem_read = 1'b1; imem_resp = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 14 || c == 15 || c == 16 || c == 20) begin
        checks++;
        if (s_stall_cnt !== 4'((c > 15) ? 15 : c)) begin
          $display("FAIL sat_cycle%0d: stall_cnt=%0d, required %0d",
                   c, s_stall_cnt, (c > 15) ? 15 : c);
        end else passed++;
      end
    end
    checks++;
    if (stall_cnt !== 32'd20) begin
      $display("FAIL sat_wide: stall_cnt=%0d, required 20", stall_cnt);
    end else passed++;
  endtask

  task automatic test_reset_mid_stall();
    refill();
    branch_miss = 1'b1; imem_resp = 1'b0;
    tick();
    branch_miss = 1'b0;
    tick();
    // Async reset between edges while a fetch is outstanding and discard is set
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (stage_valid !== 4'b0000 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0 ||
        reg_en !== 4'b0000 || load_pc !== 1'b0) begin
      $display("FAIL midrst: valid=%b stall=%0d flush=%0d reg_en=%b load_pc=%b, required 0000/0/0/0000/0",
               stage_valid, stall_cnt, flush_cnt, reg_en, load_pc);
    end else passed++;
    tick();
    rst_n = 1'b1;
    imem_resp = 1'b1;
    #1;
    checks++;
    if (reg_bubble !== 4'b0000 || load_pc !== 1'b1) begin
      $display("FAIL midrst_resp: bubble=%b load_pc=%b, required 0000/1", reg_bubble, load_pc);
    end else passed++;
    tick();
    checks++;
    if (stage_valid !== 4'b0001) begin
      $display("FAIL midrst_valid: valid=%b, required 0001", stage_valid);
    end else passed++;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_dmem_wait();
    test_branch();
    test_branch_dwait();
    test_saturation();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised pipeline controller for the RV32I in-order core. It replaces the hardwired "load_pc=1 / clear IF/ID on branch" logic with per-register enable/bubble control. It covers imem/dmem wait stalls, load-use interlock, branch-redirect squash and discard of stale in-flight fetches, and it tracks per-register valid bits and saturating stall/flush counters. It sits beside the cpu datapath and drives the enables of the N-1 inter-stage registers and the PC.

Parameters:
NUM_STAGES, 5, pipeline depth; number of inter-stage registers NR = NUM_STAGES-1 (index 0 = IF/ID … NR-1 = MEM/WB)
EX_IDX, 2, index of the register written by EX (EX/MEM); branch redirect resolves in EX
MEM_IDX, 3, index of the register written by MEM (MEM/WB)
REG_AW, 5, register-address width
CNT_W, 32, width of perf counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
imem_read  in  1  fetch request issued this cycle
imem_resp  in  1  fetch data valid
dmem_req  in  1  MEM-stage instruction requests dmem (read|write)
dmem_resp  in  1  dmem access complete
branch_miss  in  1  EX-stage redirect (pcmux != pc_plus4)
id_rs1, id_rs2  in  REG_AW  source regs of instruction in IF/ID
id_use_rs1, id_use_rs2  in  1  source actually read
ex_rd  in  REG_AW  dest reg of instruction in ID/EX
ex_is_load  in  1  ID/EX instruction is a load
load_pc  out  1  PC register enable
reg_en  out  NR  per-register load enable
reg_bubble  out  NR  when reg_en[i]=1, register i loads NOP/zero instead of next data
stage_valid  out  NR  registered valid bit per register
stall_cnt  out  CNT_W  cycles with any stall asserted
flush_cnt  out  CNT_W  number of redirect events

Behaviour:
- Reset (async, rst_n=0): stage_valid=0, discard=0, stall_cnt=0, flush_cnt=0; combinational outputs forced load_pc=0, reg_en=0, reg_bubble=0. First enables appear the cycle after rst_n rises.
- Derived: i_wait = imem_read & ~imem_resp; d_wait = stage_valid[EX_IDX] & dmem_req & ~dmem_resp; lu = stage_valid[1] & ex_is_load & ex_rd!=0 & stage_valid[0] & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Priority, highest first: d_wait > branch_miss > lu > i_wait > run.
- d_wait: load_pc=0; reg_en[0..MEM_IDX-1]=0 (frozen); reg_en[MEM_IDX]=1 with bubble; registers above MEM_IDX advance normally.
- branch_miss (qualified by stage_valid[EX_IDX-1]): load_pc=1; reg_en[0..EX_IDX-1]=1 with bubble=1 (squash IF/ID and ID/EX); later registers advance. flush_cnt+1. If i_wait that cycle, set discard.
- lu: load_pc=0; reg_en[0]=0; reg_en[1]=1 bubble; rest advance.
- i_wait: load_pc=0; reg_en[0]=1 bubble; rest advance.
- run: all reg_en=1, bubble=0, load_pc=1; except when discard=1 and imem_resp=1: reg_en[0] bubble=1, discard clears that cycle.
- discard: 1-bit register; set only as above, cleared on first imem_resp after set; a second redirect while set keeps it set.
- stage_valid[i] <= reg_en[i] ? (~reg_bubble[i] & src_valid) : stage_valid[i], where src_valid = 1 for i=0 and stage_valid[i-1] otherwise.
- stall_cnt increments on any cycle with d_wait|lu|i_wait. Both counters saturate at all-ones, with no wrap.
- Simultaneous d_wait & branch_miss: the branch is ignored that cycle and re-evaluated once EX/MEM is released. Because EX is frozen, branch_miss persists, so no redirect is lost.
- Reset mid-stall clears all state immediately; an outstanding fetch response after reset is not discarded.

Test Plan:
- Reset then 6 cycles with imem_resp=1, dmem_req=0 -> stage_valid fills 0001,0011,0111,1111; load_pc=1 from cycle 1; counters 0.
- Load x5 in ID/EX, IF/ID add reads rs1=x5 -> exactly 1 cycle load_pc=0, reg_en[0]=0, reg_bubble[1]=1; stall_cnt=1. With ex_rd=x0 -> no stall.
- dmem_req with dmem_resp delayed 3 cycles -> regs 0..2 frozen 3 cycles, MEM/WB gets 3 bubbles, stall_cnt+3, fourth cycle resumes.
- branch_miss with imem_read pending, resp 2 cycles later -> IF/ID, ID/EX bubbled, flush_cnt=1, the late response is bubbled (discard 1→0), and the next response loads normally.
- branch_miss coincident with 2-cycle d_wait -> no flush during d_wait; flush occurs on the release cycle; flush_cnt=1.
- Force counters to near saturation (CNT_W=4): 20 stall cycles -> stall_cnt holds at 15.
